load_mem_unit: RTL and testbench
================================

# load_mem_unit

Execute-stage load unit that consumes the decoded load fields (base register value, 12-bit immediate, destination register, 3-bit load control) and performs the matching data-memory read. It computes the effective address, checks alignment, issues a word-aligned read over a valid/ready request channel, waits for the response, then extracts, sign- or zero-extends and returns the value for register writeback. It sits between load decode and the register-file write port, and is the consumer of the `LB`/`LH`/`LW`/`LBU`/`LHU` encodings from `processor_defines.sv`.

## Interface
- No parameters; data and address width fixed at 32.
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  load request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- rs1_data  input  32  base register value
- imm  input  12  signed offset
- rd  input  5  destination register
- load_control  input  3  `LB`/`LH`/`LW`/`LBU`/`LHU` from `processor_defines.sv`
- mem_req_valid  output  1  memory read request
- mem_req_ready  input  1  memory accepts request
- mem_addr  output  32  word-aligned address (bits [1:0] = 0)
- mem_rsp_valid  input  1  read data valid
- mem_rsp_data  input  32  little-endian word read
- wb_valid  output  1  one-cycle writeback pulse
- wb_rd  output  5  writeback register
- wb_data  output  32  extended load result
- fault  output  1  misaligned/illegal load, valid with wb_valid

## Operation
- States: IDLE, REQ, WAIT, WB.
- IDLE: req_ready=1. On req_valid: latch rd, load_control, byte offset; ea = rs1_data + sign_extend(imm), modulo 2^32 (wrap, no overflow flag).
- Alignment: LH/LHU with ea[0]=1, LW with ea[1:0]≠0, or load_control not one of the five defines → latch fault, go to WB without memory access.
- Otherwise go to REQ with mem_addr = {ea[31:2],2'b00}.
- REQ: mem_req_valid=1, mem_addr stable; stay until mem_req_ready, then WAIT.
- WAIT: stay until mem_rsp_valid; capture extended data, go to WB.
- mem_rsp_valid in IDLE/REQ/WB ignored.
- WB: wb_valid=1 one cycle with wb_rd, wb_data, fault; then IDLE.
- Extraction: byte = mem_rsp_data[8*ea[1:0]+:8]; half = mem_rsp_data[16*ea[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
- Fault: wb_data=0; wb_rd = latched rd (regfile must gate on fault).
- rd=0: access performed normally, wb_data forced to 0.

## Timing
- All outputs registered. Reset values: req_ready=1 (state IDLE), mem_req_valid=0, mem_addr=0, wb_valid=0, wb_rd=0, wb_data=0, fault=0.
- Accept at edge T → mem_req_valid from T+1; with mem_req_ready at T+1 and mem_rsp_valid at T+2, wb_valid at T+3 (minimum latency 3).
- Fault path: accept at T → wb_valid, fault=1 at T+1.
- One outstanding request; no new request accepted until WB completes (req_ready=0 in REQ/WAIT/WB, high again the cycle after WB).
- mem_req_valid may not drop before mem_req_ready; mem_addr unchanged while waiting.
- Asserting rst in any state: immediately returns to IDLE with reset outputs; a response arriving later is dropped.

## Test plan
- LW: rs1=0x1000, imm=0x004, rd=5, zero-wait memory returns 0xDEADBEEF → mem_addr=0x1004, wb_valid at T+3, wb_rd=5, wb_data=0xDEADBEEF, fault=0.
- LB/LBU: rs1=0x2000, imm=0xFFF (−1 → ea=0x1FFF), data 0x80xxxxxx → mem_addr=0x1FFC; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- LH ea=0x3002 with data 0x8001xxxx → 0xFFFF8001; LHU → 0x00008001; LH ea=0x3001 → no mem_req_valid, fault=1, wb_data=0 at T+1.
- Back-pressure: mem_req_ready low 4 cycles, mem_rsp_valid delayed 3 more → mem_req_valid/mem_addr held stable, req_ready=0 throughout, single wb_valid pulse.
- rd=0 with LW returning 0x12345678 → wb_valid=1, wb_data=0; rs1=0xFFFFFFFC, imm=0x008 → mem_addr=0x00000004 (wrap).
- rst asserted in WAIT, then stray mem_rsp_valid → outputs at reset values, no wb_valid; next request behaves normally.

Source files
------------

// File: rtl/load_mem_unit_if.sv
// ============================================================================
// Module      : load_mem_unit_if
// Description : Request, data-memory read and writeback bundle for the load unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_mem_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] rs1_data;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [2:0]  load_control;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;

    // Environment side: issues loads, models memory, observes writeback
    modport master (
        output req_valid, rs1_data, imm, rd, load_control,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, mem_req_valid, mem_addr,
        input  wb_valid, wb_rd, wb_data, fault
    );

    modport slave (
        input  req_valid, rs1_data, imm, rd, load_control,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, mem_req_valid, mem_addr,
        output wb_valid, wb_rd, wb_data, fault
    );
endinterface

`default_nettype wire

// File: rtl/load_mem_unit.sv
// ============================================================================
// Module      : load_mem_unit
// Description : Execute-stage load unit: EA, alignment check, word read, extend.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_mem_unit (
    input  wire logic            clk,
    input  wire logic            rst,
    load_mem_unit_if.slave       bus
);
    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LH  = 3'b001;
    localparam logic [2:0] c_LW  = 3'b010;
    localparam logic [2:0] c_LBU = 3'b100;
    localparam logic [2:0] c_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  ctl_q, ctl_d;
    logic [1:0]  off_q, off_d;
    logic        req_ready_q, req_ready_d;
    logic        mem_req_valid_q, mem_req_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        fault_q, fault_d;

    logic [31:0] w_ea;
    logic        w_bad;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_ea = bus.rs1_data + {{20{bus.imm[11]}}, bus.imm};

    // Unknown encodings fault alongside misaligned halfword/word accesses
    always_comb begin
        w_bad = 1'b0;
        case (bus.load_control)
            c_LB, c_LBU: w_bad = 1'b0;
            c_LH, c_LHU: w_bad = w_ea[0];
            c_LW:        w_bad = (w_ea[1:0] != 2'b00);
            default:     w_bad = 1'b1;
        endcase
    end

    assign w_byte = bus.mem_rsp_data[{off_q, 3'b000} +: 8];
    assign w_half = bus.mem_rsp_data[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        w_ext = bus.mem_rsp_data;
        case (ctl_q)
            c_LB:    w_ext = {{24{w_byte[7]}}, w_byte};
            c_LBU:   w_ext = {24'd0, w_byte};
            c_LH:    w_ext = {{16{w_half[15]}}, w_half};
            c_LHU:   w_ext = {16'd0, w_half};
            default: w_ext = bus.mem_rsp_data;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        rd_d            = rd_q;
        ctl_d           = ctl_q;
        off_d           = off_q;
        req_ready_d     = 1'b0;
        mem_req_valid_d = 1'b0;
        mem_addr_d      = mem_addr_q;
        wb_valid_d      = 1'b0;
        wb_rd_d         = wb_rd_q;
        wb_data_d       = wb_data_q;
        fault_d         = fault_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    rd_d  = bus.rd;
                    ctl_d = bus.load_control;
                    off_d = w_ea[1:0];
                    if (w_bad) begin
                        state_d    = S_WB;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = bus.rd;
                        wb_data_d  = 32'd0;
                        fault_d    = 1'b1;
                    end else begin
                        state_d         = S_REQ;
                        mem_req_valid_d = 1'b1;
                        mem_addr_d      = {w_ea[31:2], 2'b00};
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = S_WAIT;
                end else begin
                    mem_req_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_d    = S_WB;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = (rd_q == 5'd0) ? 32'd0 : w_ext;
                    fault_d    = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rd_q            <= 5'd0;
            ctl_q           <= 3'd0;
            off_q           <= 2'd0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= 32'd0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= 5'd0;
            wb_data_q       <= 32'd0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_q            <= rd_d;
            ctl_q           <= ctl_d;
            off_q           <= off_d;
            req_ready_q     <= req_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            wb_valid_q      <= wb_valid_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
            fault_q         <= fault_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.fault         = fault_q;
endmodule

`default_nettype wire

// File: tb/tb_load_mem_unit.sv
// ============================================================================
// Module      : tb_load_mem_unit
// Description : Randomised self-checking bench for load_mem_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_mem_unit;
    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LH  = 3'b001;
    localparam logic [2:0] c_LW  = 3'b010;
    localparam logic [2:0] c_LBU = 3'b100;
    localparam logic [2:0] c_LHU = 3'b101;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    load_mem_unit_if bus ();

    load_mem_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_ea(input logic [31:0] rs1, input logic [11:0] imm);
        int off;
        off = (imm >= 12'd2048) ? int'(imm) - 4096 : int'(imm);
        return rs1 + off;
    endfunction

    function automatic bit model_fault(input logic [2:0] ctl, input logic [31:0] ea);
        if (ctl == c_LB || ctl == c_LBU) return 1'b0;
        if (ctl == c_LH || ctl == c_LHU) return (ea % 2) != 0;
        if (ctl == c_LW) return (ea % 4) != 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_data(input logic [2:0] ctl, input logic [31:0] ea,
                                               input logic [31:0] word, input logic [4:0] rd);
        logic [31:0] b, h;
        int unsigned lo;
        if (rd == 0) return 32'd0;
        lo = ea % 4;
        b  = (word >> (8 * lo)) & 32'hFF;
        h  = (word >> (16 * (lo / 2))) & 32'hFFFF;
        case (ctl)
            c_LB:    return (b >= 128) ? b - 32'd256 : b;
            c_LBU:   return b;
            c_LH:    return (h >= 32768) ? h - 32'd65536 : h;
            c_LHU:   return h;
            default: return word;
        endcase
    endfunction

    task automatic drive_idle();
        bus.req_valid     = 1'b0;
        bus.rs1_data      = $urandom;
        bus.imm           = 12'($urandom);
        bus.rd            = 5'($urandom);
        bus.load_control  = 3'($urandom);
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = $urandom;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    endtask

    // Called at a negedge; issues one load and acts as the memory for it
    task automatic run_load(input logic [31:0] rs1, input logic [11:0] imm, input logic [4:0] rd,
                            input logic [2:0] ctl, input logic [31:0] word,
                            input int req_lat, input int rsp_lat);
        logic [31:0] ea, addr;
        bit          f;
        ea   = model_ea(rs1, imm);
        f    = model_fault(ctl, ea);
        addr = {ea[31:2], 2'b00};
        wait_ready();
        bus.req_valid    = 1'b1;
        bus.rs1_data     = rs1;
        bus.imm          = imm;
        bus.rd           = rd;
        bus.load_control = ctl;
        @(negedge clk);
        drive_idle();
        check("req_ready_busy", 32'(bus.req_ready), 32'd0);
        if (f) begin
            check("flt_wb_valid", 32'(bus.wb_valid), 32'd1);
            check("flt_fault", 32'(bus.fault), 32'd1);
            check("flt_wb_data", bus.wb_data, 32'd0);
            check("flt_wb_rd", 32'(bus.wb_rd), 32'(rd));
            check("flt_no_mem", 32'(bus.mem_req_valid), 32'd0);
            @(negedge clk);
            check("flt_wb_pulse", 32'(bus.wb_valid), 32'd0);
            check("flt_ready_back", 32'(bus.req_ready), 32'd1);
            return;
        end
        check("mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
        check("mem_addr", bus.mem_addr, addr);
        check("wb_early", 32'(bus.wb_valid), 32'd0);
        for (int i = 0; i < req_lat; i++) begin
            if ($urandom_range(1) == 1) bus.mem_rsp_valid = 1'b1;
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            check("req_hold_valid", 32'(bus.mem_req_valid), 32'd1);
            check("req_hold_addr", bus.mem_addr, addr);
            check("req_hold_ready", 32'(bus.req_ready), 32'd0);
            check("req_hold_wb", 32'(bus.wb_valid), 32'd0);
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check("req_dropped", 32'(bus.mem_req_valid), 32'd0);
        check("wait_ready", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < rsp_lat; i++) begin
            @(negedge clk);
            check("wait_no_wb", 32'(bus.wb_valid), 32'd0);
            check("wait_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = word;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = $urandom;
        check("wb_valid", 32'(bus.wb_valid), 32'd1);
        check("wb_rd", 32'(bus.wb_rd), 32'(rd));
        check("wb_data", bus.wb_data, model_data(ctl, ea, word, rd));
        check("wb_fault", 32'(bus.fault), 32'd0);
        check("wb_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("wb_pulse", 32'(bus.wb_valid), 32'd0);
        check("ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
        check({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'd0);
        check({tag, "_wb_data"}, bus.wb_data, 32'd0);
        check({tag, "_fault"}, 32'(bus.fault), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] ctl;
        logic [31:0] rs1;
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        run_load(32'h0000_1000, 12'h004, 5'd5, c_LW, 32'hDEAD_BEEF, 0, 0);
        run_load(32'h0000_2000, 12'hFFF, 5'd7, c_LB, 32'h8012_3456, 0, 0);
        run_load(32'h0000_2000, 12'hFFF, 5'd7, c_LBU, 32'h8012_3456, 1, 1);
        run_load(32'h0000_3000, 12'h002, 5'd9, c_LH, 32'h8001_1234, 0, 0);
        run_load(32'h0000_3000, 12'h002, 5'd9, c_LHU, 32'h8001_1234, 0, 2);
        run_load(32'h0000_3000, 12'h001, 5'd9, c_LH, 32'h8001_1234, 0, 0);
        run_load(32'h0000_3000, 12'h002, 5'd4, c_LW, 32'h1111_2222, 0, 0);
        run_load(32'h0000_3000, 12'h000, 5'd4, 3'b011, 32'h1111_2222, 0, 0);
        run_load(32'h0000_4000, 12'h010, 5'd3, c_LW, 32'hCAFE_F00D, 4, 3);
        run_load(32'h0000_5000, 12'h000, 5'd0, c_LW, 32'h1234_5678, 0, 0);
        run_load(32'hFFFF_FFFC, 12'h008, 5'd1, c_LW, 32'hA5A5_5A5A, 0, 0);

        // Reset while waiting for the read response; the late response must be dropped
        wait_ready();
        bus.req_valid    = 1'b1;
        bus.rs1_data     = 32'h0000_6000;
        bus.imm          = 12'h008;
        bus.rd           = 5'd12;
        bus.load_control = c_LW;
        @(negedge clk);
        drive_idle();
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h5555_AAAA;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check("stray_no_wb", 32'(bus.wb_valid), 32'd0);
        check("stray_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        check("stray_no_wb2", 32'(bus.wb_valid), 32'd0);
        run_load(32'h0000_6000, 12'h00A, 5'd12, c_LHU, 32'hBEEF_0001, 1, 0);

        for (int n = 0; n < 200; n++) begin
            ctl = 3'($urandom);
            if ($urandom_range(3) != 0) begin
                case ($urandom_range(4))
                    0: ctl = c_LB;
                    1: ctl = c_LH;
                    2: ctl = c_LW;
                    3: ctl = c_LBU;
                    default: ctl = c_LHU;
                endcase
            end
            rs1 = $urandom;
            if ($urandom_range(1) == 1) rs1[1:0] = 2'b00;
            run_load(rs1, 12'($urandom), 5'($urandom), ctl, $urandom,
                     int'($urandom_range(3)), int'($urandom_range(3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
